// File: rtl/aes_iter_core.sv
// Iterative AES-128 encrypt/decrypt core: 32-bit word load/unload, on-the-fly key
// schedule, and one shared computed S-box bank that handles both directions.
module aes_iter_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         selEncDec,
    input  logic [127:0] key_in,
    input  logic [31:0]  data_in,
    output logic [31:0]  data_out,
    output logic [7:0]   signals
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOAD, S_KEYEXP, S_ADD0, S_ROUND, S_OUT0, S_OUT123
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d, k0_q, k0_d, rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d, signals_q, signals_d;
    logic [31:0]  data_out_q, data_out_d;
    logic [3:0]   cnt_q, cnt_d, rnd_q, rnd_d;
    logic         dec_q, dec_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse, and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
        logic [7:0] x, y;
        x = inv ? (rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05) : a;
        y = gf_inv(x);
        return inv ? y : (y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[31-8*i -: 8] = sbox(w[31-8*i -: 8], inv);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    // Row i of the (Inv)MixColumns matrix is the coefficient vector rotated right by i
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [31:0]  m;
        logic [127:0] o;
        logic [7:0]   acc;
        m = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(m[31-8*((j-i+4)%4) -: 8], s[127-32*c-8*j -: 8]);
                o[127-32*c-8*i -: 8] = acc;
            end
        end
        return o;
    endfunction

    logic [31:0]  col_q, col_sb, ks_in, ks_sw;
    logic [127:0] rk_fwd, rk_bwd, w_bwd;
    logic         ks_back;

    always_comb begin
        col_q = '0;
        for (int c = 0; c < 4; c++)
            if (cnt_q[1:0] == 2'(c)) col_q = st_q[127-32*c -: 32];
        col_sb  = sub_word(col_q, dec_q);
        ks_back = dec_q && (state_q == S_ROUND);
        // Stepping backward needs the old w3, which is recovered as w3' ^ w2'
        ks_in   = ks_back ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
        ks_sw   = sub_word({ks_in[23:0], ks_in[31:24]}, 1'b0) ^ {rcon_q, 24'h0};
        rk_fwd[127:96] = rk_q[127:96] ^ ks_sw;
        rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
        rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
        rk_fwd[31:0]   = rk_q[31:0]  ^ rk_fwd[63:32];
        rk_bwd = {rk_q[127:96] ^ ks_sw, rk_q[95:64] ^ rk_q[127:96],
                  rk_q[63:32] ^ rk_q[95:64], rk_q[31:0] ^ rk_q[63:32]};
        w_bwd  = shift_rows(st_q, 1'b1) ^ rk_bwd;
    end

    always_comb begin
        // NOTE: every value gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;  st_d = st_q;      k0_d = k0_q;   rk_d = rk_q;
        rcon_d  = rcon_q;   dec_d = dec_q;    cnt_d = cnt_q; rnd_d = rnd_q;
        signals_d  = 8'h01;
        data_out_d = '0;

        // Outputs are registered from the current state, so they trail the FSM by one edge
        unique case (state_q)
            S_LOAD:   signals_d = 8'h02;
            S_KEYEXP: signals_d = 8'h04;
            S_ADD0, S_ROUND: signals_d = 8'h08;
            S_OUT0:   begin signals_d = 8'h10; data_out_d = st_q[127:96]; end
            S_OUT123: begin signals_d = 8'h20; data_out_d = col_q; end
            default:  signals_d = 8'h01;
        endcase

        unique case (state_q)
            S_ARM: begin
                st_d[127:96] = data_in;
                cnt_d   = 4'd1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                for (int c = 1; c < 4; c++)
                    if (cnt_q[1:0] == 2'(c)) st_d[127-32*c -: 32] = data_in;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    state_d = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                rk_d   = rk_fwd;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    rk_d    = dec_q ? rk_fwd : k0_q;
                    rcon_d  = dec_q ? 8'h36 : 8'h01;
                    state_d = S_ADD0;
                end
            end
            S_ADD0: begin
                st_d    = st_q ^ rk_q;
                cnt_d   = '0;
                rnd_d   = 4'd1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q != 4'd4) begin
                    for (int c = 0; c < 4; c++)
                        if (cnt_q[1:0] == 2'(c)) st_d[127-32*c -: 32] = col_sb;
                end else begin
                    if (dec_q) begin
                        rk_d   = rk_bwd;
                        rcon_d = inv_xtime(rcon_q);
                        st_d   = (rnd_q == 4'd10) ? w_bwd : mix_cols(w_bwd, 1'b1);
                    end else begin
                        rk_d   = rk_fwd;
                        rcon_d = xtime(rcon_q);
                        st_d   = ((rnd_q == 4'd10) ? shift_rows(st_q, 1'b0)
                                 : mix_cols(shift_rows(st_q, 1'b0), 1'b0)) ^ rk_fwd;
                    end
                    cnt_d = '0;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == 4'd10) state_d = S_OUT0;
                end
            end
            S_OUT0: begin
                cnt_d   = 4'd1;
                state_d = S_OUT123;
            end
            S_OUT123: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_ARM;  k0_d = key_in;  rk_d = key_in;  dec_d = selEncDec;
            rcon_d  = 8'h01;  cnt_d = '0;     rnd_d = '0;
            signals_d  = 8'h01;
            data_out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch and wins over start.
        if (!reset) begin
            state_q <= S_IDLE;  st_q <= '0;    k0_q <= '0;   rk_q <= '0;
            rcon_q  <= '0;      dec_q <= 1'b0; cnt_q <= '0;  rnd_q <= '0;
            signals_q  <= 8'h01;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;  st_q <= st_d;    k0_q <= k0_d;    rk_q <= rk_d;
            rcon_q  <= rcon_d;   dec_q <= dec_d;  cnt_q <= cnt_d;  rnd_q <= rnd_d;
            signals_q  <= signals_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign signals  = signals_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors run back-to-back, an abort
// during round 5, and a reset during key expansion.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         selEncDec = 1'b0;
    logic [127:0] key_in = '0;
    logic [31:0]  data_in = '0;
    logic [31:0]  data_out;
    logic [7:0]   signals;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         dec;
        logic [127:0] key;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    aes_iter_core dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .selEncDec (selEncDec),
        .key_in    (key_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .signals   (signals)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int w);
        return b[127-32*w -: 32];
    endfunction

    // Starts vector idx at the current negedge. L0 is the edge after start drops.
    // If abort_at > 0, returns at the negedge after edge L<abort_at>.
    task automatic run_op(input int idx, input int abort_at);
        vec_t v;
        logic seen_out0;
        v = vecs[idx];
        start = 1'b1;  key_in = v.key;  selEncDec = v.dec;  data_in = $urandom();
        @(negedge clk);
        check("arm_signals", {24'h0, signals}, 32'h01);
        check("arm_data_out", data_out, 32'h0);
        start = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        selEncDec = ~v.dec;
        for (int w = 0; w < 4; w++) begin
            data_in = word_of(v.din, w);
            @(negedge clk);
        end
        data_in = $urandom();
        seen_out0 = 1'b0;
        for (int n = 4; n <= 64; n++) begin
            @(negedge clk);
            if (signals == 8'h10) seen_out0 = 1'b1;
            if (n == 30) check("round_signals", {24'h0, signals}, 32'h08);
            if (n == abort_at) begin
                check("no_early_out0", {31'h0, seen_out0}, 32'h0);
                return;
            end
        end
        check("no_early_out0", {31'h0, seen_out0}, 32'h0);
        @(negedge clk);
        check("out0_signals", {24'h0, signals}, 32'h10);
        check("out_word0", data_out, word_of(v.exp, 0));
        for (int w = 1; w < 4; w++) begin
            @(negedge clk);
            check("out123_signals", {24'h0, signals}, 32'h20);
            check($sformatf("out_word%0d", w), data_out, word_of(v.exp, w));
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[3] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};

        reset = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_signals", {24'h0, signals}, 32'h01);
        check("reset_data_out", data_out, 32'h0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_signals", {24'h0, signals}, 32'h01);

        // Each operation is started right after the previous last word
        for (int i = 0; i < 4; i++) run_op(i, 0);

        run_op(0, 37);
        run_op(2, 0);

        run_op(3, 8);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_signals", {24'h0, signals}, 32'h01);
        check("midreset_data_out", data_out, 32'h0);
        reset = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                if (signals == 8'h10 || data_out != 32'h0) seen = 1'b1;
            end
            check("midreset_no_output", {31'h0, seen}, 32'h0);
        end
        check("final_idle_signals", {24'h0, signals}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative AES-128 encrypt/decrypt engine with a 32-bit data port and a 128-bit key port. Each block is loaded as four 32-bit words after a `start` pulse. The engine then expands the key and runs 10 rounds, using a computed (GF(2^8) inverse + affine) S-box instead of lookup tables. It presents the result as four 32-bit words, flagged by a one-hot `signals` status bus. It serves as the single-rail reference core.

## Interface
No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled 0 on an edge returns the block to IDLE.
- `start` in 1: level request. Any edge sampled 1 aborts the current operation and arms a new load.
- `selEncDec` in 1: 1 = decrypt, 0 = encrypt.
- `key_in` in 128: cipher key, FIPS-197 byte order (bits 127:120 = key byte 0).
- `data_in` in 32: input block word, most significant word first.
- `data_out` out 32: output block word, most significant word first. 0 outside output cycles.
- `signals` out 8: one-hot state.
  - bit0 IDLE, bit1 LOAD, bit2 KEYEXP, bit3 ROUND, bit4 OUT0 (first output word), bit5 OUT123.
  - bits 7:6 always 0.

## Operation
- **Reset.** State IDLE, `signals`=8'h01, `data_out`=0, all registers cleared.
- **Start.** On every edge with `start`=1, regardless of state:
  - register `key_in` into K0 and into the working key RK; register `selEncDec`;
  - go to ARM, which reports as IDLE, `signals`=8'h01.
- **LOAD.** The first edge with `start`=0 after ARM captures `data_in` as word0 (state bits 127:96). The next three edges capture word1, word2 and word3.
  - `signals`=8'h02 during the three cycles between captures.
- **KEYEXP, 10 cycles.** RK advances one forward AES key-schedule step per cycle, so after 10 cycles RK = rk10.
  - Step: w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon starts at 8'h01 and is multiplied by x in GF(2^8) per step (…8'h80 → 8'h1b → 8'h36).
  - Decrypt keeps RK = rk10.
  - Encrypt reloads RK from K0 and resets rcon to 8'h01 on the last KEYEXP cycle.
- **ADD0, 1 cycle, reported as ROUND.** state ^= RK, i.e. rk0 (encrypt) or rk10 (decrypt).
- **ROUND, 10 rounds × 5 cycles.**
  - Cycles 1–4: column c (0..3) of the state passes through four S-boxes. Encrypt uses the forward S-box; decrypt uses the inverse S-box, i.e. inverse affine then GF inverse, with 0 mapping to 0.
  - Cycle 5, encrypt:
    - RK steps forward;
    - state = MixColumns(ShiftRows(state)) ^ RK_next;
    - MixColumns is skipped in round 10.
  - Cycle 5, decrypt, with InvShiftRows applied to the S-boxed state:
    - RK steps backward: w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'; w0 = w0' ^ SubWord(RotWord(w3)) ^ rcon.
    - rcon starts at 8'h36 and is divided by x per step.
    - state = InvMixColumns(InvShiftRows(S) ^ RK_prev); InvMixColumns is skipped in round 10.
  - Because SubBytes is bytewise, the ShiftRows/SubBytes order is interchangeable, so one S-box bank serves both directions.
- **OUT.**
  - OUT0, 1 cycle: `data_out` = state[127:96], `signals`=8'h10.
  - OUT123, 3 cycles: `data_out` = state[95:64], then [63:32], then [31:0]; `signals`=8'h20.
  - Then IDLE, `data_out`=0, `signals`=8'h01.
- **Start or reset mid-operation.**
  - `start`=1 during any state aborts and restarts.
  - `reset`=0 wins over `start`.
- **Bus behaviour.** `key_in` and `data_in` are ignored outside the cycles above. `start` held high for many cycles simply re-arms every cycle.

## Timing
- Let edge L0 be the first edge with `start`=0 after `start`=1.
  - Words are captured at L0..L3.
  - KEYEXP covers edges L4..L13.
  - ADD0 is at L14.
  - Rounds cover L15..L64.
  - State OUT0 is entered at edge L65; word0 is valid from L65+ until L66.
- Output words are on consecutive cycles with no stall.
- Total from L0 to the OUT0 entry: 65 edges, identical for encrypt and decrypt.
- All outputs are registered.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles with `start`=1 → `signals`=8'h01, `data_out`=0.
- **Encrypt, FIPS-197 App. B.** `selEncDec`=0, key 2b7e151628aed2a6abf7158809cf4f3c, words 3243f6a8, 885a308d, 313198a2, e0370734.
  - At OUT0 (65 edges after L0): `signals`=8'h10, words 3925841d, 02dc09fb, dc118597, 196a0b32, then `signals`=8'h01.
- **Decrypt, FIPS-197 C.1.** `selEncDec`=1, key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff.
- **Back-to-back.** Decrypt B's ciphertext directly after the B encryption with no idle gap → 3243f6a8885a308d313198a2e0370734. `signals` must not be 8'h10 before the new OUT0.
- **Abort.** Assert `start` during round 5, then load the C.1 vector → only the C.1 result is produced, with the exact 65-edge latency.
- **Reset mid-operation.** Pull `reset` low during KEYEXP → IDLE next edge, no OUT0 ever asserted.
